// File: rtl/i2c_target_regs.sv
// I2C target for the dice configuration/status register file.
// Oversamples SCL/SDA and turns bus transfers into register write strobes and read fetches.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h48,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_strobe,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_ACK,
    ST_WDATA,
    ST_RD_LOAD,
    ST_RDATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync;
  logic [1:0]  sda_sync;
  logic [1:0]  raw;
  logic [1:0]  filt;
  logic [1:0]  filt_q;
  logic [2:0]  flt_cnt [2];
  logic        scl_f;
  logic        sda_f;
  logic        scl_rise;
  logic        scl_fall;
  logic        start_cond;
  logic        stop_cond;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx_byte;
  logic [7:0]  tx;
  logic [7:0]  ptr;
  logic [1:0]  load_step;
  logic        rw;
  logic        ack_phase;
  logic        sda_oe_q;

  // Index 0 carries SCL, index 1 carries SDA.
  assign raw = {sda_sync[1], scl_sync[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      filt     <= 2'b11;
      filt_q   <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      filt_q   <= filt;
      // A level flips only after FILTER_LEN consecutive disagreeing samples.
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == 3'(FILTER_LEN - 1)) begin
          filt[i]    <= raw[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 3'd1;
        end
      end
    end
  end

  assign scl_f      = filt[0];
  assign sda_f      = filt[1];
  assign scl_rise   = filt[0] & ~filt_q[0];
  assign scl_fall   = ~filt[0] & filt_q[0];
  assign start_cond = ~filt[1] & filt_q[1] & scl_f;
  assign stop_cond  = filt[1] & ~filt_q[1] & scl_f;
  assign rx_byte    = {shreg[6:0], sda_f};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      ptr       <= '0;
      load_step <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_strobe <= 1'b0;
      rd_addr   <= '0;
    end else begin
      wr_en     <= 1'b0;
      rd_strobe <= 1'b0;
      if (start_cond) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_cond) begin
        state    <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state     <= ST_ADDR_ACK;
                rw        <= rx_byte[0];
                busy      <= 1'b1;
                ack_phase <= 1'b0;
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          // For reads the fetch runs during the ACK bit so bit 7 is ready at its release edge.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_q  <= 1'b1;
              ack_phase <= 1'b1;
              if (rw) begin
                state     <= ST_RD_LOAD;
                load_step <= '0;
              end
            end else begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_SUB;
            end
          end
          ST_SUB: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr       <= rx_byte;
              ack_phase <= 1'b0;
              state     <= ST_ACK;
            end
          end
          ST_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_q  <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_WDATA;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              wr_en     <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_byte;
              ptr       <= ptr + 8'd1;
              ack_phase <= 1'b0;
              state     <= ST_ACK;
            end
          end
          ST_RD_LOAD: begin
            case (load_step)
              2'd0: begin
                rd_strobe <= 1'b1;
                rd_addr   <= ptr;
                load_step <= 2'd1;
              end
              2'd1: load_step <= 2'd2;
              2'd2: begin
                tx        <= rd_data;
                load_step <= 2'd3;
              end
              default: if (scl_fall) begin
                sda_oe_q <= ~tx[7];
                tx       <= {tx[6:0], 1'b0};
                bit_cnt  <= 4'd1;
                state    <= ST_RDATA;
              end
            endcase
          end
          ST_RDATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_q <= 1'b0;
              state    <= ST_RD_ACK;
            end else begin
              sda_oe_q <= ~tx[7];
              tx       <= {tx[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (!sda_f) begin
              ptr       <= ptr + 8'd1;
              load_step <= '0;
              state     <= ST_RD_LOAD;
            end else begin
              busy  <= 1'b0;
              state <= ST_IGNORE;
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Reset must free the bus without waiting for a clock edge.
  assign sda_oe = sda_oe_q & ~rst;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C initiator, write/read scoreboards,
// table of write transactions plus hand sequences for abort, reset, glitch and read.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_strobe;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  logic [7:0]  reg_mem [256];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  int          n_checks;
  int          n_errors;
  logic        oe_seen;
  logic        busy_seen;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] sub;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
  } wr_vec_t;

  wr_vec_t vecs [5];

  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_oe;
  assign rd_data = reg_mem[rd_addr];

  i2c_target_regs #(.DEV_ADDR(7'h48), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: every strobe pops what the stimulus predicted.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (wr_en || rd_strobe) check("strobe_exclusive", {31'd0, wr_en & rd_strobe}, 32'd0);
    if (wr_en) begin
      if (exp_wr_q.size() == 0) check("unexpected_wr", {16'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else check("wr_addr_data", {16'd0, wr_addr, wr_data}, {16'd0, exp_wr_q.pop_front()});
    end
    if (rd_strobe) begin
      if (exp_rd_q.size() == 0) check("unexpected_rd", {24'd0, rd_addr}, 32'hFFFF_FFFF);
      else check("rd_addr", {24'd0, rd_addr}, {24'd0, exp_rd_q.pop_front()});
    end
  end

  // Driver tasks: enter and leave with SCL low (except start from idle / stop).
  task automatic send_bit(input logic b, input logic glitch, output logic seen);
    wait_clk(10);
    sda_m = b;
    if (glitch) begin
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(2);
      scl_m = 1'b0;
      wait_clk(4);
    end else begin
      wait_clk(10);
    end
    scl_m = 1'b1;
    wait_clk(10);
    seen = sda_in;
    wait_clk(10);
    scl_m = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(10);
    scl_m = 1'b1;
    wait_clk(20);
    sda_m = 1'b0;
    wait_clk(20);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(10);
    sda_m = 1'b0;
    wait_clk(10);
    scl_m = 1'b1;
    wait_clk(20);
    sda_m = 1'b1;
    wait_clk(20);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch_bit == i, s);
    send_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(nack, 1'b0, s);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {11'd0, sda_oe, wr_en, rd_strobe, busy, wr_addr, wr_data, rd_addr}, 32'd0);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    n_checks  = 0;
    n_errors  = 0;
    oe_seen   = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 256; i++) reg_mem[i] = 8'(i);
    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;

    vecs[0] = '{dev: 8'h90, sub: 8'h05, d0: 8'hA1, d1: 8'h3C, ack: 1'b1};
    vecs[1] = '{dev: 8'h92, sub: 8'h05, d0: 8'hA1, d1: 8'h3C, ack: 1'b0};
    vecs[2] = '{dev: 8'h90, sub: 8'hFF, d0: 8'h11, d1: 8'h22, ack: 1'b1};
    vecs[3] = '{dev: 8'h90, sub: 8'($urandom_range(0, 255)), d0: 8'($urandom_range(0, 255)),
                d1: 8'($urandom_range(0, 255)), ack: 1'b1};
    vecs[4] = '{dev: 8'h91 ^ 8'h80, sub: 8'h40, d0: 8'h77, d1: 8'h88, ack: 1'b0};

    wait_clk(5);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    wait_clk(20);

    // Table-driven write transactions.
    for (int v = 0; v < 5; v++) begin
      oe_seen   = 1'b0;
      busy_seen = 1'b0;
      bus_start();
      write_byte(vecs[v].dev, -1, ack);
      check($sformatf("v%0d_addr_ack", v), {31'd0, ack}, {31'd0, vecs[v].ack});
      check($sformatf("v%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].ack});
      if (vecs[v].ack) begin
        exp_wr_q.push_back({vecs[v].sub, vecs[v].d0});
        exp_wr_q.push_back({8'(vecs[v].sub + 8'd1), vecs[v].d1});
      end
      write_byte(vecs[v].sub, -1, ack);
      check($sformatf("v%0d_sub_ack", v), {31'd0, ack}, {31'd0, vecs[v].ack});
      write_byte(vecs[v].d0, -1, ack);
      check($sformatf("v%0d_d0_ack", v), {31'd0, ack}, {31'd0, vecs[v].ack});
      write_byte(vecs[v].d1, -1, ack);
      check($sformatf("v%0d_d1_ack", v), {31'd0, ack}, {31'd0, vecs[v].ack});
      bus_stop();
      check($sformatf("v%0d_busy_after_stop", v), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_wr_drained", v), exp_wr_q.size(), 32'd0);
      if (!vecs[v].ack) begin
        check($sformatf("v%0d_no_oe", v), {31'd0, oe_seen}, 32'd0);
        check($sformatf("v%0d_no_busy", v), {31'd0, busy_seen}, 32'd0);
      end
    end

    // STOP after four data bits: the partial byte is dropped.
    bus_start();
    write_byte(8'h90, -1, ack);
    check("abort_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h20, -1, ack);
    check("abort_sub_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, s);
    bus_stop();
    wait_clk(10);
    check("abort_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of an address byte.
    bus_start();
    send_bit(1'b1, 1'b0, s);
    send_bit(1'b0, 1'b0, s);
    send_bit(1'b0, 1'b0, s);
    wait_clk(5);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_addr");
    scl_m = 1'b1;
    wait_clk(5);
    sda_m = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(20);

    // Reset while the target is pulling SDA low for the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h90 >> i), 1'b0, s);
    wait_clk(10);
    sda_m = 1'b1;
    wait_clk(10);
    scl_m = 1'b1;
    wait_clk(5);
    check("ack_driven_before_rst", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_releases_sda", {31'd0, sda_oe}, 32'd0);
    check_reset_outputs("rst_mid_ack");
    wait_clk(5);
    rst = 1'b0;
    wait_clk(20);
    check("post_rst_wr_drained", exp_wr_q.size(), 32'd0);

    // SCL glitch shorter than the filter during a data bit.
    bus_start();
    write_byte(8'h90, -1, ack);
    check("glitch_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h30, -1, ack);
    exp_wr_q.push_back({8'h30, 8'h5B});
    write_byte(8'h5B, 4, ack);
    check("glitch_data_ack", {31'd0, ack}, 32'd1);
    bus_stop();
    check("glitch_wr_drained", exp_wr_q.size(), 32'd0);

    // Pointer set by write, repeated START, two-byte read ending in NACK.
    reg_mem[8'h10] = 8'hC3;
    reg_mem[8'h11] = 8'h5A;
    bus_start();
    write_byte(8'h90, -1, ack);
    write_byte(8'h10, -1, ack);
    check("rd_sub_ack", {31'd0, ack}, 32'd1);
    bus_start();
    exp_rd_q.push_back(8'h10);
    exp_rd_q.push_back(8'h11);
    write_byte(8'h91, -1, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    read_byte(1'b0, d);
    check("rd_byte0", {24'd0, d}, 32'hC3);
    read_byte(1'b1, d);
    check("rd_byte1", {24'd0, d}, 32'h5A);
    wait_clk(10);
    check("rd_nack_release", {31'd0, sda_oe}, 32'd0);
    check("rd_nack_busy", {31'd0, busy}, 32'd0);
    bus_stop();
    check("rd_drained", exp_rd_q.size(), 32'd0);
    check("wr_final_drained", exp_wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
